// File: rtl/synapse_weight_loader_if.sv
// Byte stream in, table write port out: the signal bundle between the host
// streamer, the weight loader and the synapse weight table.
interface synapse_weight_loader_if #(
    parameter int unsigned ADDR_W = 5
) ();
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    logic [BYTE_W-1:0] in_byte;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_data;

    // Host side: drives the byte stream, observes the table writes.
    modport master (
        output in_byte, in_valid, in_last,
        input  in_ready, w_en, w_addr, w_data
    );

    // Loader side: consumes the byte stream, drives the table write port.
    modport slave (
        input  in_byte, in_valid, in_last,
        output in_ready, w_en, w_addr, w_data
    );
endinterface

// File: rtl/synapse_weight_loader.sv
// Synapse weight loader: packs a byte stream into 32-bit words (byte n lands
// in word n/4, lane n%4) and writes them into the weight table at init time.
module synapse_weight_loader #(
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    synapse_weight_loader_if.slave        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf,
    output logic [ADDR_W:0]               word_count
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [LANE_W-1:0] TOP_LANE  = LANE_W'(3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                in_ready_q, in_ready_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [WORD_W-1:0]   w_data_q, w_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;

    logic [CNT_W-1:0]    next_count_c;
    logic [WORD_W-1:0]   word_c;
    logic                accept_c;

    // Count including a write currently on the bus; this is also the address
    // of the next word, so a write issued during a w_en cycle gets no gap.
    assign next_count_c = word_count_q + CNT_W'(w_en_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            pack_q       <= '0;
            in_ready_q   <= 1'b0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            in_ready_q   <= in_ready_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            word_count_q <= word_count_d;
        end
    end

    // Next-state, packing and write-issue logic.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        pack_d       = pack_q;
        w_en_d       = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        ovf_d        = ovf_q;
        word_count_d = next_count_c;

        accept_c = bus.in_valid & in_ready_q;

        // Pack register holds zeros in unfilled lanes, so this is also the
        // zero-padded word for an early in_last.
        word_c = pack_q;
        word_c[{lane_q, 3'b000} +: BYTE_W] = bus.in_byte;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    lane_d       = '0;
                    pack_d       = '0;
                    ovf_d        = 1'b0;
                    word_count_d = '0;
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    if ((lane_q == TOP_LANE) || bus.in_last) begin
                        w_en_d   = 1'b1;
                        w_addr_d = next_count_c[ADDR_W-1:0];
                        w_data_d = word_c;
                        pack_d   = '0;
                        lane_d   = '0;
                        if (bus.in_last || (next_count_c[ADDR_W-1:0] == LAST_ADDR)) begin
                            state_d = S_FINISH;
                        end
                    end else begin
                        pack_d = word_c;
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    lane_d       = '0;
                    pack_d       = '0;
                    ovf_d        = 1'b0;
                    word_count_d = '0;
                end else if (bus.in_valid) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_FINISH);
        done_d     = (state_d == S_DONE);
    end

    assign bus.in_ready = in_ready_q;
    assign bus.w_en     = w_en_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_data   = w_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ovf          = ovf_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_synapse_weight_loader.sv
// Bench for synapse_weight_loader: drives byte loads, predicts table writes
// from the byte-to-word packing rule and checks them in a separate monitor.
module tb_synapse_weight_loader;

    localparam int unsigned NUM_WORDS = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned MAX_BYTES = 4 * NUM_WORDS;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [ADDR_W:0]   word_count;

    synapse_weight_loader_if #(.ADDR_W(ADDR_W)) bus ();

    synapse_weight_loader #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .word_count (word_count)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endfunction

    // Reference model: byte n goes to word n/4 at bit 8*(n%4); the load writes
    // ceil(n/4) words, never more than the table holds.
    function automatic void predict(input int n);
        int words;
        logic [31:0] w;
        words = (n + 3) / 4;
        if (words > int'(NUM_WORDS)) words = int'(NUM_WORDS);
        for (int i = 0; i < words; i++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * i + b < n) w = w | (32'(tx_q[4 * i + b]) << (8 * b));
            end
            exp_addr.push_back(32'(i));
            exp_data.push_back(w);
        end
    endfunction

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        logic [31:0] ea;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (rst && bus.w_en) begin
                pulses++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                             bus.w_addr, bus.w_data);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("w_addr", 32'(bus.w_addr), ea);
                    check("w_data", bus.w_data, ed);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers tx_q[0..n-1]; gap_pct% of cycles idle; start raised once at byte start_at.
    task automatic drive_load(input int n, input bit use_last, input int gap_pct, input int start_at);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        bit  start_done = 1'b0;
        while (idx < n && cyc < 5000) begin
            @(negedge clk);
            start = 1'b0;
            if (start_at >= 0 && idx == start_at && !start_done) begin
                start = 1'b1;
                start_done = 1'b1;
            end
            bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
            bus.in_byte  = bus.in_valid ? tx_q[idx] : 8'($urandom);
            bus.in_last  = bus.in_valid ? (use_last && idx == n - 1) : 1'($urandom);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d bytes accepted, required %0d", idx, n);
        end
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic fill_seq(input int n, input logic [7:0] base);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(base + 8'(i));
    endtask

    initial begin
        int p0;
        int n;
        bit ul;
        rst          = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_byte  = 8'h00;
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_w_en", 32'(bus.w_en), 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Two full words, back-to-back.
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        fill_seq(8, 8'h01);
        predict(8);
        p0 = pulses;
        drive_load(8, 1'b1, 0, -1);
        wait_done();
        check("s1_word_count", 32'(word_count), 32'd2);
        check("s1_ovf", 32'(ovf), 32'd0);
        check("s1_pulses", 32'(pulses - p0), 32'd2);
        check("s1_drained", 32'(exp_addr.size()), 32'd0);

        // Partial flush.
        pulse_start();
        fill_seq(6, 8'h11);
        predict(6);
        p0 = pulses;
        drive_load(6, 1'b1, 0, -1);
        wait_done();
        check("s2_word_count", 32'(word_count), 32'd2);
        check("s2_pulses", 32'(pulses - p0), 32'd2);
        check("s2_drained", 32'(exp_addr.size()), 32'd0);

        // Full table, no in_last.
        pulse_start();
        fill_seq(int'(MAX_BYTES), 8'h00);
        predict(int'(MAX_BYTES));
        p0 = pulses;
        drive_load(int'(MAX_BYTES), 1'b0, 0, -1);
        check("s3_ready_low", 32'(bus.in_ready), 32'd0);
        wait_done();
        check("s3_word_count", 32'(word_count), 32'(NUM_WORDS));
        check("s3_pulses", 32'(pulses - p0), 32'(NUM_WORDS));
        check("s3_drained", 32'(exp_addr.size()), 32'd0);
        check("s3_ovf_clear", 32'(ovf), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("s3_ovf_set", 32'(ovf), 32'd1);
        check("s3_done_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("s3_ovf_sticky", 32'(ovf), 32'd1);
        pulse_start();
        check("s3_restart_ovf", 32'(ovf), 32'd0);
        check("s3_restart_count", 32'(word_count), 32'd0);

        // Gaps plus an ignored start in the middle of the load.
        fill_seq(8, 8'h01);
        predict(8);
        p0 = pulses;
        drive_load(8, 1'b1, 40, 3);
        wait_done();
        check("s4_word_count", 32'(word_count), 32'd2);
        check("s4_pulses", 32'(pulses - p0), 32'd2);
        check("s4_drained", 32'(exp_addr.size()), 32'd0);

        // Reset mid-load: only the completed first word is written.
        pulse_start();
        fill_seq(6, 8'h31);
        predict(4);
        drive_load(6, 1'b0, 0, -1);
        rst = 1'b0;
        #1;
        check("s5_rst_w_en", 32'(bus.w_en), 32'd0);
        check("s5_rst_count", 32'(word_count), 32'd0);
        check("s5_rst_idle", {29'd0, busy, done, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("s5_drained", 32'(exp_addr.size()), 32'd0);
        pulse_start();
        tx_q.delete();
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        tx_q.push_back(8'hCC);
        tx_q.push_back(8'hDD);
        predict(4);
        p0 = pulses;
        drive_load(4, 1'b1, 0, -1);
        wait_done();
        check("s5_pulses", 32'(pulses - p0), 32'd1);
        check("s5_word_count", 32'(word_count), 32'd1);

        // Single byte: FINISH cycle, then DONE.
        pulse_start();
        tx_q.delete();
        tx_q.push_back(8'h5A);
        predict(1);
        p0 = pulses;
        drive_load(1, 1'b1, 0, -1);
        check("s6_not_done_yet", 32'(done), 32'd0);
        @(negedge clk);
        check("s6_done_timing", 32'(done), 32'd1);
        check("s6_pulses", 32'(pulses - p0), 32'd1);
        check("s6_word_count", 32'(word_count), 32'd1);

        // Randomized loads.
        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(1, MAX_BYTES));
            ul = (n < int'(MAX_BYTES)) ? 1'b1 : 1'($urandom);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            pulse_start();
            predict(n);
            p0 = pulses;
            drive_load(n, ul, 30, int'($urandom_range(0, n - 1)));
            wait_done();
            check("rnd_word_count", 32'(word_count), 32'((n + 3) / 4));
            check("rnd_pulses", 32'(pulses - p0), 32'((n + 3) / 4));
            check("rnd_drained", 32'(exp_addr.size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
